wgt_skew_feeder: RTL and testbench

- Sits directly downstream of the weight address controller and the weight RAM.
- Each read the controller issues returns one SYSTOLIC_SIZE-lane weight vector from the RAM one cycle later. This block:
  - aligns the controller's read_en and read_wgt_size to that returned data;
  - zeroes lanes at or beyond read_wgt_size, so a partial filter group never injects stale weights;
  - skews the vector diagonally (lane k delayed k cycles) to feed the systolic array's weight inputs.
- Also reports pipeline occupancy, a drain-complete pulse, and a vector count for layer sequencing.

---
 rtl/wgt_skew_feeder.sv | 127 ++++++++++++
 tb/tb_wgt_skew_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wgt_skew_feeder.sv
// Aligns weight-RAM read data to the controller strobe and masks lanes beyond the valid size.
// It also skews lane k by k cycles for the systolic array and reports busy, drain and vector count.
module wgt_skew_feeder #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  read_en,
  input  logic [4:0]                            read_wgt_size,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   rd_data,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   wgt_out,
  output logic [SYSTOLIC_SIZE-1:0]              wgt_valid,
  output logic                                  busy,
  output logic                                  drain_done,
  output logic [12:0]                           wgt_count
);

  localparam logic [5:0]  SYS_W   = 6'(SYSTOLIC_SIZE);
  localparam logic [12:0] CNT_MAX = 13'h1FFF;

  logic                     r_en_d;
  logic [4:0]               r_size_d;
  logic [5:0]               w_eff;
  logic [SYSTOLIC_SIZE-1:0] r_occ;
  logic [SYSTOLIC_SIZE-1:0] w_occ_nxt;
  logic                     w_busy_nxt;
  logic                     r_busy;
  logic                     r_drain;
  logic [12:0]              r_cnt;

  // Align stage: loads every cycle, including the flush cycle, so a read concurrent with start survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d   <= 1'b0;
      r_size_d <= 5'd0;
    end else begin
      r_en_d   <= read_en;
      r_size_d <= read_wgt_size;
    end
  end

  // Effective lane count, clamped to the array width
  always_comb begin
    w_eff = {1'b0, r_size_d};
    if ({1'b0, r_size_d} > SYS_W) begin
      w_eff = SYS_W;
    end else begin
      w_eff = {1'b0, r_size_d};
    end
  end

  // Next-state of the slot-occupancy chain and the busy flag it implies
  always_comb begin
    w_occ_nxt = '0;
    if (start) begin
      w_occ_nxt = '0;
    end else begin
      w_occ_nxt[0] = r_en_d;
      for (int s = 1; s < SYSTOLIC_SIZE; s++) begin
        w_occ_nxt[s] = r_occ[s-1];
      end
    end
    w_busy_nxt = read_en | (|w_occ_nxt);
  end

  // Occupancy, busy, drain pulse and saturating vector counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ   <= '0;
      r_busy  <= 1'b0;
      r_drain <= 1'b0;
      r_cnt   <= 13'd0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_busy  <= w_busy_nxt;
      // drain pulse coincides with the first idle cycle; a flush never reports a drain
      r_drain <= r_busy & ~w_busy_nxt & ~start;
      if (start) begin
        r_cnt <= 13'd0;
      end else if (r_en_d && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 13'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign busy       = r_busy;
  assign drain_done = r_drain;
  assign wgt_count  = r_cnt;

  for (genvar k = 0; k < SYSTOLIC_SIZE; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_dat [0:k];
    logic [k:0]            r_vld;
    logic                  w_lane_on;

    assign w_lane_on = r_en_d & (6'(k) < w_eff);

    // Mask stage followed by k skew registers; data and valid travel together
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= '0;
        for (int s = 0; s <= k; s++) begin
          r_dat[s] <= '0;
        end
      end else if (start) begin
        r_vld <= '0;
        for (int s = 0; s <= k; s++) begin
          r_dat[s] <= '0;
        end
      end else begin
        r_vld[0] <= w_lane_on;
        r_dat[0] <= w_lane_on ? rd_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= k; s++) begin
          r_vld[s] <= r_vld[s-1];
          r_dat[s] <= r_dat[s-1];
        end
      end
    end

    assign wgt_out[k*DATA_WIDTH +: DATA_WIDTH] = r_dat[k];
    assign wgt_valid[k]                        = r_vld[k];
  end

endmodule

// File: tb/tb_wgt_skew_feeder.sv
// Scoreboard bench for wgt_skew_feeder: stimulus pushes per-lane expectations with their due cycle,
// a negedge monitor pops/compares lanes and checks busy, drain_done and wgt_count against an interval model.
module tb_wgt_skew_feeder;
  localparam int N  = 16;
  localparam int DW = 16;
  localparam int SW = N * DW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          read_en;
  logic [4:0]    read_wgt_size;
  logic [SW-1:0] rd_data;
  logic [SW-1:0] wgt_out;
  logic [N-1:0]  wgt_valid;
  logic          busy;
  logic          drain_done;
  logic [12:0]   wgt_count;

  wgt_skew_feeder #(.SYSTOLIC_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .read_en(read_en),
    .read_wgt_size(read_wgt_size), .rd_data(rd_data), .wgt_out(wgt_out),
    .wgt_valid(wgt_valid), .busy(busy), .drain_done(drain_done), .wgt_count(wgt_count)
  );

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } exp_t;

  exp_t        lane_q [N][$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        pend_v = 1'b0;
  logic [SW-1:0] pend_d = '0;

  // monitor model state
  int          m_from = 1;
  int          m_until = -1;
  int          m_acc = 0;
  int          m_pend [$];
  logic        prev_busy = 1'b0;
  logic        prev_start = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] rvec();
    logic [SW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = 16'($urandom);
    return v;
  endfunction

  // Drive one cycle of stimulus; called just after a rising edge
  task automatic step(input logic re, input logic [4:0] sz, input logic [SW-1:0] d, input logic st);
    int eff;
    read_en       = re;
    read_wgt_size = sz;
    start         = st;
    rd_data       = pend_v ? pend_d : rvec();
    if (st) begin
      for (int k = 0; k < N; k++)
        while (lane_q[k].size() > 0 && lane_q[k][$].cyc > cyc) void'(lane_q[k].pop_back());
    end
    if (re) begin
      eff = (int'(sz) > N) ? N : int'(sz);
      for (int k = 0; k < eff; k++) lane_q[k].push_back('{cyc + 2 + k, d[k*DW +: DW]});
    end
    pend_v = re;
    pend_d = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_out"}, 64'(|wgt_out), 64'd0);
    chk({nm, "_valid"}, 64'(wgt_valid), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_drain"}, 64'(drain_done), 64'd0);
    chk({nm, "_count"}, 64'(wgt_count), 64'd0);
  endtask

  // Monitor: compare this cycle's outputs, then fold in this cycle's inputs
  always @(negedge clk) begin
    logic eb, ed;
    if (!rst_n) begin
      m_from = 1; m_until = -1; m_acc = 0; m_pend.delete();
      prev_busy = 1'b0; prev_start = 1'b0;
    end else begin
      while (m_pend.size() > 0 && m_pend[0] <= cyc - 2) begin
        void'(m_pend.pop_front());
        if (m_acc < 8191) m_acc++;
      end
      eb = (cyc >= m_from) && (cyc <= m_until);
      ed = prev_busy && !eb && !prev_start;
      chk("busy", 64'(busy), 64'(eb));
      chk("drain_done", 64'(drain_done), 64'(ed));
      chk("wgt_count", 64'(wgt_count), 64'(m_acc));
      for (int k = 0; k < N; k++) begin
        if (lane_q[k].size() > 0 && lane_q[k][0].cyc == cyc) begin
          chk($sformatf("lane%0d_valid", k), 64'(wgt_valid[k]), 64'd1);
          chk($sformatf("lane%0d_data", k), 64'(wgt_out[k*DW +: DW]), 64'(lane_q[k][0].d));
          void'(lane_q[k].pop_front());
        end else begin
          chk($sformatf("lane%0d_idle_valid", k), 64'(wgt_valid[k]), 64'd0);
          chk($sformatf("lane%0d_idle_data", k), 64'(wgt_out[k*DW +: DW]), 64'd0);
        end
      end
      if (start) begin
        if (m_until > cyc) m_until = cyc;
        m_pend.delete();
        m_acc = 0;
      end
      if (read_en) begin
        if (m_until < cyc) m_from = cyc + 1;
        m_until = cyc + 17;
        m_pend.push_back(cyc);
      end
      prev_busy  = eb;
      prev_start = start;
    end
  end

  initial begin
    logic [SW-1:0] v;
    rst_n = 1'b0; start = 1'b0; read_en = 1'b0; read_wgt_size = 5'd0; rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    idle(2);

    // single full vector, lane k = k+1
    for (int k = 0; k < N; k++) v[k*DW +: DW] = 16'(k + 1);
    step(1'b1, 5'd16, v, 1'b0);
    idle(22);

    // partial group of 5 lanes, all ones
    v = {N{16'hFFFF}};
    step(1'b1, 5'd5, v, 1'b0);
    idle(22);

    // 9-read burst, data = read index
    for (int i = 0; i < 9; i++) step(1'b1, 5'd16, {N{16'(i)}}, 1'b0);
    idle(24);

    // clamp and zero size
    step(1'b1, 5'd20, rvec(), 1'b0);
    idle(20);
    step(1'b1, 5'd0, rvec(), 1'b0);
    idle(20);
    step(1'b1, 5'd31, rvec(), 1'b0);
    step(1'b1, 5'd0, rvec(), 1'b0);
    step(1'b1, 5'd16, rvec(), 1'b0);
    idle(20);

    // flush at lane 7's output cycle with a concurrent read
    for (int i = 0; i < 9; i++) step(1'b1, 5'd16, rvec(), 1'b0);
    step(1'b1, 5'd12, rvec(), 1'b1);
    idle(22);
    // flush with nothing concurrent
    for (int i = 0; i < 6; i++) step(1'b1, 5'(i + 3), rvec(), 1'b0);
    step(1'b0, 5'd0, '0, 1'b1);
    idle(22);

    // async reset mid-burst, asserted between edges
    for (int i = 0; i < 6; i++) step(1'b1, 5'd16, rvec(), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    for (int k = 0; k < N; k++) lane_q[k].delete();
    pend_v = 1'b0;
    read_en = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 5'd16, rvec(), 1'b0);
    idle(22);

    // random traffic
    for (int i = 0; i < 500; i++)
      step(1'b1 & ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), rvec(),
           $urandom_range(0, 40) == 0);
    idle(22);

    // counter saturation
    for (int i = 0; i < 8200; i++) step(1'b1, 5'($urandom_range(0, 31)), rvec(), 1'b0);
    idle(24);

    for (int k = 0; k < N; k++) chk($sformatf("lane%0d_leftover", k), 64'(lane_q[k].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
